isp_sharpen_cfg_ctrl: RTL and testbench
=======================================

# isp_sharpen_cfg_ctrl

Frame-synchronous configuration controller for the sharpen stage. It accepts the 81 luma kernel weights and the sharpen strength over a valid/ready write port into a shadow bank. On commit it checks that the kernel sums to unity gain. It then copies the shadow bank to the active outputs at the next vertical-sync rising edge, so the sharpen core never sees a kernel change mid-frame. Its outputs drive the sharpen core's `luma_kernel` and `sharpen_strength` inputs directly.

## Interface
- `SHARP_WEIGHT_BITS`, 20: width of each unsigned kernel weight; unity gain is 2^SHARP_WEIGHT_BITS.
- `SUM_TOL`, 81: maximum allowed |kernel sum − 2^SHARP_WEIGHT_BITS|.
- `pclk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cfg_valid`  in  1: write request.
- `cfg_ready`  out  1: write port can accept.
- `cfg_addr`  in  7: 0–80 select kernel tap (row-major, 40 = centre); 81 selects strength.
- `cfg_data`  in  SHARP_WEIGHT_BITS: write data; strength uses bits [11:0].
- `cfg_commit`  in  1: one-cycle request to validate and schedule the shadow bank.
- `cfg_busy`  out  1: high whenever state ≠ IDLE.
- `cfg_err`  out  1: sticky error flag.
- `in_vsync`  in  1: frame sync, same signal that feeds the sharpen core.
- `update_done`  out  1: one-cycle pulse when new active values appear.
- `luma_kernel`  out  81*SHARP_WEIGHT_BITS: active kernel; tap i is at bits [SHARP_WEIGHT_BITS*i +: SHARP_WEIGHT_BITS].
- `sharpen_strength`  out  12: active strength, signed.

## Operation
- **Storage**
  - Shadow bank: 81 weights plus the strength value.
  - Active bank: drives `luma_kernel` and `sharpen_strength`.
- **IDLE**
  - `cfg_ready` = 1.
  - A write occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_addr` ≤ 81: updates the shadow entry.
  - `cfg_addr` ≥ 82: write is dropped and `cfg_err` is set.
  - `cfg_commit` clears `cfg_err`, zeroes the sum and index, and moves to CHECK.
  - A write in the same cycle as `cfg_commit` lands first and is included in the check.
- **CHECK**
  - Takes 81 cycles; `cfg_ready` = 0.
  - Adds shadow tap `idx` (0→80, one per cycle) into an accumulator of width SHARP_WEIGHT_BITS+7.
  - In the cycle with idx = 80, the final sum (including tap 80) is compared against the target:
    - within `SUM_TOL` → PENDING;
    - otherwise → IDLE with `cfg_err` = 1; the active bank is unchanged.
  - The strength value is not checked.
- **PENDING**
  - `cfg_ready` = 0.
  - A rising edge is detected as `in_vsync` && !vsync_d, where vsync_d is `in_vsync` registered every cycle regardless of state.
  - On a rising edge → APPLY.
  - Edges that occur during CHECK or IDLE are ignored; the controller waits for the next edge.
- **APPLY**
  - Lasts one cycle.
  - The active bank loads from the shadow bank; `update_done` is registered high.
  - Next state is IDLE.
- `cfg_commit` outside IDLE is ignored.
- The shadow bank keeps its contents after a commit, so a partial rewrite followed by a recommit is legal.

## Timing
- **Reset values** (any cycle with `rst` = 1, including mid-CHECK or mid-PENDING):
  - state IDLE; shadow and active banks all zero;
  - `luma_kernel` = 0, `sharpen_strength` = 0 (the core then passes the pixel through unchanged);
  - `cfg_ready` = 1 from the first cycle after reset;
  - `cfg_busy` = 0, `cfg_err` = 0, `update_done` = 0, vsync_d = 0.
  - Any pending commit is lost.
- **Commit sequence**, with commit sampled at cycle T:
  - CHECK occupies T+1 … T+81;
  - PENDING is first active at T+82, or IDLE with `cfg_err` = 1 at T+82.
- **Apply sequence**, with the vsync rising edge sampled in PENDING at cycle R:
  - APPLY at R+1;
  - active outputs change and `update_done` = 1 at R+2 only;
  - IDLE and `cfg_ready` = 1 at R+2.
- An edge in the very first PENDING cycle (T+82) is honoured.
- `cfg_ready` and `cfg_busy` are registered from state and are never combinational from `cfg_valid`.
- The active outputs never change except in the cycle after APPLY and on reset.

## Test plan
- **Reset defaults.** Assert `rst` for 3 cycles → all outputs at reset values; `cfg_ready` = 1 on the first cycle after reset.
- **Valid kernel applied at vsync.** Write tap40 = 2^20 − 1 and tap0 = 1, others 0; strength = 0x100; commit at T → `cfg_busy` at T+1, PENDING at T+82, `cfg_err` = 0. Raise `in_vsync` at R → `update_done` only at R+2; `luma_kernel` tap40 = 0xFFFFF, tap0 = 1; `sharpen_strength` = 0x100.
- **Bad kernel rejected.** All taps = 0, commit → IDLE at T+82 with `cfg_err` = 1; active outputs unchanged; no `update_done` on a following vsync.
- **Tolerance edge.** Sum = 2^20 + 81 → accepted. Sum = 2^20 + 82 → rejected.
- **Vsync during CHECK.** Vsync edge at T+40 → ignored; apply occurs only after the next edge. `cfg_valid` held high during CHECK/PENDING → no shadow change, `cfg_ready` = 0.
- **Error and reset cases.** Write to `cfg_addr` = 90 → `cfg_err` = 1, cleared by the next commit. `rst` asserted in PENDING → the following vsync causes no update; outputs stay zero.

Source files
------------

// File: rtl/isp_sharpen_cfg_ctrl.sv
// Frame-synchronous shadow/active configuration for the sharpen stage.
// Kernel writes land in a shadow bank, are sum-checked on commit and copied to the outputs at the next vsync rise.
module isp_sharpen_cfg_ctrl #(
   parameter int SHARP_WEIGHT_BITS = 20,
   parameter int SUM_TOL           = 81
) (
   input  logic                           pclk,
   input  logic                           rst,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [6:0]                     cfg_addr,
   input  logic [SHARP_WEIGHT_BITS-1:0]   cfg_data,
   input  logic                           cfg_commit,
   output logic                           cfg_busy,
   output logic                           cfg_err,
   input  logic                           in_vsync,
   output logic                           update_done,
   output logic [81*SHARP_WEIGHT_BITS-1:0] luma_kernel,
   output logic [11:0]                    sharpen_strength,
   output logic [1:0]                     cfg_state
);

   localparam int W  = SHARP_WEIGHT_BITS;
   localparam int AW = SHARP_WEIGHT_BITS + 7;
   localparam longint UNITY = longint'(1) << W;
   localparam logic [AW-1:0] SUM_LO = AW'(UNITY - longint'(SUM_TOL));
   localparam logic [AW-1:0] SUM_HI = AW'(UNITY + longint'(SUM_TOL));

   // Handshake: a write transfers on a rising pclk edge where cfg_valid && cfg_ready;
   // cfg_ready is a flop that is high exactly while the controller is in IDLE.
   typedef enum logic [1:0] {IDLE, CHECK, PENDING, APPLY} state_t;

   state_t        state, next_state;
   logic [W-1:0]  shadow_k [81];
   logic [11:0]   shadow_s;
   logic [AW-1:0] acc, acc_sum;
   logic [6:0]    idx;
   logic          vsync_d, vsync_rise, sum_ok, wr_en;

   assign cfg_state  = state;
   assign wr_en      = cfg_valid && cfg_ready;
   assign vsync_rise = in_vsync && !vsync_d;
   assign acc_sum    = acc + AW'(shadow_k[idx]);
   assign sum_ok     = (acc_sum >= SUM_LO) && (acc_sum <= SUM_HI);

   always_ff @(posedge pclk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cfg_commit) next_state = CHECK;
         CHECK:   if (idx == 7'd80) next_state = sum_ok ? PENDING : IDLE;
         PENDING: if (vsync_rise) next_state = APPLY;
         APPLY:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < 81; i++) shadow_k[i] <= '0;
         shadow_s         <= '0;
         luma_kernel      <= '0;
         sharpen_strength <= '0;
         acc              <= '0;
         idx              <= '0;
         vsync_d          <= 1'b0;
         cfg_ready        <= 1'b1;
         cfg_busy         <= 1'b0;
         cfg_err          <= 1'b0;
         update_done      <= 1'b0;
      end else begin
         vsync_d     <= in_vsync;
         cfg_ready   <= (next_state == IDLE);
         cfg_busy    <= (next_state != IDLE);
         update_done <= (state == APPLY);

         if (wr_en) begin
            if (cfg_addr <= 7'd80)      shadow_k[cfg_addr] <= cfg_data;
            else if (cfg_addr == 7'd81) shadow_s <= cfg_data[11:0];
            else                        cfg_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               // Commit outranks a same-cycle bad-address error: the new check starts clean.
               if (cfg_commit) begin
                  cfg_err <= 1'b0;
                  acc     <= '0;
                  idx     <= '0;
               end
            end
            CHECK: begin
               acc <= acc_sum;
               idx <= idx + 7'd1;
               if (idx == 7'd80 && !sum_ok) cfg_err <= 1'b1;
            end
            APPLY: begin
               for (int i = 0; i < 81; i++) luma_kernel[i*W +: W] <= shadow_k[i];
               sharpen_strength <= shadow_s;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_isp_sharpen_cfg_ctrl.sv
// Bench for isp_sharpen_cfg_ctrl: directed sequence with randomized kernels
// checked against an array-based model of shadow/active banks.
module tb_isp_sharpen_cfg_ctrl;

   localparam int W = 20;
   localparam longint UNITY = longint'(1) << W;

   logic              pclk, rst, cfg_valid, cfg_ready, cfg_commit, cfg_busy, cfg_err;
   logic              in_vsync, update_done;
   logic [6:0]        cfg_addr;
   logic [W-1:0]      cfg_data;
   logic [81*W-1:0]   luma_kernel;
   logic [11:0]       sharpen_strength;
   logic [1:0]        cfg_state;

   isp_sharpen_cfg_ctrl dut (
      .pclk(pclk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .in_vsync(in_vsync), .update_done(update_done),
      .luma_kernel(luma_kernel), .sharpen_strength(sharpen_strength), .cfg_state(cfg_state)
   );

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int tests = 0;
   int fails = 0;

   // reference model
   logic [W-1:0] m_shadow [81];
   logic [W-1:0] m_active [81];
   logic [11:0]  m_str, m_act_str;
   bit           m_pending;

   task automatic model_reset();
      for (int i = 0; i < 81; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_str = '0; m_act_str = '0; m_pending = 0;
   endtask

   function automatic longint model_sum();
      longint s = 0;
      for (int i = 0; i < 81; i++) s += longint'(m_shadow[i]);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_active(input string tag);
      logic [81*W-1:0] exp;
      int bad;
      for (int i = 0; i < 81; i++) exp[i*W +: W] = m_active[i];
      tests++;
      assert (luma_kernel === exp && sharpen_strength === m_act_str) else begin
         fails++;
         bad = 0;
         for (int i = 80; i >= 0; i--) if (luma_kernel[i*W +: W] !== exp[i*W +: W]) bad = i;
         $error("FAIL %s: tap %0d observed %h expected %h, strength observed %h expected %h",
                tag, bad, luma_kernel[bad*W +: W], exp[bad*W +: W], sharpen_strength, m_act_str);
      end
   endtask

   // driver tasks
   task automatic reset_dut();
      @(negedge pclk);
      rst = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0; in_vsync = 1'b0;
      repeat (3) @(negedge pclk);
      model_reset();
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_upd", update_done, 0);
      chk_active("rst_active");
      rst = 1'b0;
      @(negedge pclk);
      chk("ready_after_rst", cfg_ready, 1);
   endtask

   task automatic write_cfg(input int addr, input logic [W-1:0] data);
      @(negedge pclk);
      cfg_valid = 1'b1;
      cfg_addr  = 7'(addr);
      cfg_data  = data;
      @(posedge pclk);
      #1 cfg_valid = 1'b0;
      if (addr <= 80)      m_shadow[addr] = data;
      else if (addr == 81) m_str = data[11:0];
   endtask

   task automatic clear_taps();
      for (int i = 0; i < 81; i++) if (m_shadow[i] != '0) write_cfg(i, '0);
   endtask

   // Two nonzero taps whose sum is s
   task automatic set_sum(input longint s);
      longint t40;
      int k;
      clear_taps();
      t40 = UNITY - 1 - longint'($urandom_range(200, 1000));
      k = $urandom_range(0, 79);
      if (k >= 40) k++;
      write_cfg(40, W'(t40));
      write_cfg(k, W'(s - t40));
   endtask

   task automatic load_random(input longint offset);
      longint s = 0;
      for (int i = 0; i < 81; i++) begin
         if (i != 40) begin
            write_cfg(i, W'($urandom_range(1000, 4095)));
            s += longint'(m_shadow[i]);
         end
      end
      write_cfg(40, W'(UNITY + offset - s));
      write_cfg(81, W'($urandom_range(0, 4095)));
   endtask

   task automatic do_commit(input int vs_at, input bit hold_valid);
      longint s;
      bit accept;
      s = model_sum();
      accept = (s >= UNITY - 81) && (s <= UNITY + 81);
      @(negedge pclk);
      cfg_commit = 1'b1;
      @(posedge pclk);
      for (int k = 1; k <= 82; k++) begin
         @(negedge pclk);
         if (k == 1) begin
            cfg_commit = 1'b0;
            chk("busy_t1", cfg_busy, 1);
            chk("ready_t1", cfg_ready, 0);
            chk("err_clr_t1", cfg_err, 0);
            if (hold_valid) begin
               cfg_valid = 1'b1;
               cfg_addr  = 7'($urandom_range(0, 81));
               cfg_data  = W'($urandom);
            end
         end
         if (k == vs_at) in_vsync = 1'b1;
         if (k == 81) begin
            chk("busy_t81", cfg_busy, 1);
            chk("ready_t81", cfg_ready, 0);
         end
      end
      cfg_valid = 1'b0;
      chk("err_t82", cfg_err, {31'd0, !accept});
      chk("busy_t82", cfg_busy, {31'd0, accept});
      chk("ready_t82", cfg_ready, {31'd0, !accept});
      m_pending = accept;
   endtask

   task automatic pulse_vsync();
      @(negedge pclk);
      in_vsync = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      chk("upd_r1", update_done, 0);
      chk_active("active_r1");
      @(negedge pclk);
      chk("upd_r2", update_done, {31'd0, m_pending});
      if (m_pending) begin
         for (int i = 0; i < 81; i++) m_active[i] = m_shadow[i];
         m_act_str = m_str;
         m_pending = 0;
      end
      chk_active("active_r2");
      chk("ready_r2", cfg_ready, 1);
      chk("busy_r2", cfg_busy, 0);
      @(negedge pclk);
      in_vsync = 1'b0;
      chk("upd_r3", update_done, 0);
   endtask

   // directed sequence
   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0; in_vsync = 1'b0;
      cfg_addr = '0; cfg_data = '0;
      model_reset();
      reset_dut();

      // unity kernel from two taps
      write_cfg(40, 20'hFFFFF);
      write_cfg(0, 20'h1);
      write_cfg(81, 20'h100);
      do_commit(0, 0);
      pulse_vsync();
      chk("tap40", luma_kernel[40*W +: W], 32'hFFFFF);
      chk("tap0", luma_kernel[0 +: W], 32'h1);
      chk("strength", sharpen_strength, 32'h100);

      // all-zero kernel rejected, no update on vsync
      clear_taps();
      do_commit(0, 0);
      pulse_vsync();

      // tolerance boundaries
      set_sum(UNITY + 81); write_cfg(81, W'($urandom_range(0, 4095)));
      do_commit(0, 0); pulse_vsync();
      set_sum(UNITY + 82);
      do_commit(0, 0); pulse_vsync();
      set_sum(UNITY - 81);
      do_commit(0, 0); pulse_vsync();
      set_sum(UNITY - 82);
      do_commit(0, 0); pulse_vsync();

      // vsync rising mid-check is ignored; writes blocked while busy
      load_random(longint'($urandom_range(0, 162)) - 81);
      do_commit(40, 1);
      repeat (3) begin
         @(negedge pclk);
         chk("hold_no_upd", update_done, 0);
         chk("hold_busy", cfg_busy, 1);
      end
      in_vsync = 1'b0;
      pulse_vsync();

      // random kernels around the tolerance window
      for (int n = 0; n < 4; n++) begin
         load_random(longint'($urandom_range(0, 400)) - 200);
         do_commit(0, 0);
         pulse_vsync();
      end

      // bad address sets error, next commit clears it
      write_cfg(90, W'($urandom));
      @(negedge pclk);
      chk("err_badaddr", cfg_err, 1);
      chk_active("badaddr_active");
      load_random(0);
      do_commit(0, 0);
      pulse_vsync();

      // reset while pending drops the commit
      load_random(5);
      do_commit(0, 0);
      reset_dut();
      pulse_vsync();
      chk_active("post_rst_zero");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
